hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core: generates the per-stage stall and flush strobes consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards by inserting an ID/EX bubble and handles taken branches and jumps with a two-cycle front-end squash. It also freezes the pipe while the data memory is busy, watches for memory timeouts, and keeps saturating stall and flush performance counters.

## Interface
- REG_SEL, 5, register-select width
- MEM_TIMEOUT, 255, wait cycles before mem_timeout sets (1..2^CNT_WIDTH-1)
- CNT_WIDTH, 32, width of performance counters and wait counter
- clk  in  1  single core clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- id_rs1, id_rs2  in  REG_SEL  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1/rs2
- ex_rd  in  REG_SEL  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- branch_taken  in  1  EX resolved a taken branch or a jump (PC redirect this cycle)
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (flush has priority over stall in the registers)
- redirect_pending  out  1  high while in state REDIRECT
- mem_timeout  out  1  sticky memory-timeout error
- stall_count, flush_count  out  CNT_WIDTH  saturating performance counters

## Operation
- FSM states: RUN, REDIRECT. Reset → RUN.
- Derived terms:
  - mem_wait = mem_req & !mem_ready.
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority, highest first, evaluated every cycle:
  - mem_wait: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1; mem_wb_flush = 1; every other flush is 0. branch_taken and load_use are ignored because EX is frozen and re-presents them. The state is held.
  - branch_taken: if_id_flush = 1, id_ex_flush = 1, no stalls. Next state is REDIRECT from either state. flush_count increments.
  - state REDIRECT, no branch: if_id_flush = 1 to discard the stale synchronous-IMEM fetch. load_use is suppressed because ID holds a bubble. Next state is RUN.
  - load_use, in RUN only: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 (bubble); id_ex_stall = 0.
  - otherwise: all strobes are 0.
- ex_rd == 0 never creates a hazard.
- Wait counter (CNT_WIDTH bits):
  - Increments each cycle mem_wait = 1; clears to 0 on any cycle mem_wait = 0.
  - When it reaches MEM_TIMEOUT with mem_wait still 1, mem_timeout sets. It stays set until rst; stalling continues regardless.
  - The counter saturates at MEM_TIMEOUT.
- stall_count increments on every cycle pc_stall = 1 (load-use or mem_wait). It saturates at all ones.
- flush_count saturates at all ones.

## Timing
- All stall and flush outputs and redirect_pending are combinational from the current inputs and state, valid in the same cycle as the causing input. There is no registered latency.
- The state, wait counter, mem_timeout and both perf counters update on the rising clk edge after the causing cycle.
- rst has priority over everything at the edge. After reset:
  - state = RUN;
  - wait counter, stall_count, flush_count = 0;
  - mem_timeout = 0.
  With inputs idle, every strobe is 0 and redirect_pending = 0.
- rst asserted mid-mem_wait or mid-REDIRECT aborts the sequence. There are no pending effects after reset.
- Load-use penalty is 1 cycle; the next cycle re-evaluates with the load in MEM, so there is no hazard. Branch penalty is 2 cycles.
- mem_req & mem_ready in the same cycle causes no stall.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 → same cycle pc_stall = if_id_stall = id_ex_flush = 1 and id_ex_stall = 0. stall_count goes 0→1. Repeat with ex_rd = 0 or id_uses_rs2 = 0 → no strobes.
- Taken branch: branch_taken for 1 cycle → cycle T gives if_id_flush = id_ex_flush = 1. T+1 gives redirect_pending = 1 and if_id_flush = 1 only, even with a load_use pattern present. T+2 returns to RUN with all strobes 0. flush_count = 1.
- Memory wait: mem_req = 1, mem_ready = 0 for 4 cycles with branch_taken = 1 → all four stalls plus mem_wb_flush for 4 cycles, no if_id/id_ex flush, state unchanged. The cycle mem_ready = 1 gives the branch flush. stall_count = 4.
- Mem wait during REDIRECT: enter REDIRECT, then mem_wait for 2 cycles → redirect_pending is held and if_id_flush = 0 during the wait. The if_id_flush fires on the first non-wait cycle, then the state goes to RUN.
- Timeout: MEM_TIMEOUT = 3, mem_wait held for 5 cycles → mem_timeout rises after the 3rd wait cycle and stays 1 after mem_ready and mem_req drop. It clears only on rst.
- Saturation and reset: preload both counters to all ones by force or with a small CNT_WIDTH, then stall or branch → counters hold all ones. Assert rst in the middle of REDIRECT → next cycle state = RUN, all counters and mem_timeout are 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the five-stage core. It drives
//               the per-stage stall and flush strobes for the PC, IF/ID, ID/EX,
//               EX/MEM and MEM/WB registers. It handles the following cases:
//                 - load-use hazards, with a one-cycle ID/EX bubble;
//                 - taken branches and jumps, with a two-cycle front-end squash;
//                 - data-memory busy, which freezes the pipe;
//               It also raises a sticky memory-timeout flag and keeps
//               saturating stall and flush performance counters.
// Ports       : clk, rst (sync, active-high)
//               id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID source operands
//               ex_rd/ex_mem_read                     : EX destination / load
//               branch_taken                          : EX redirect this cycle
//               mem_req/mem_ready                     : MEM access handshake
//               *_stall / *_flush                     : pipeline strobes (comb)
//               redirect_pending                      : FSM in REDIRECT
//               mem_timeout                           : sticky timeout error
//               stall_count/flush_count               : saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_SEL     = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   id_rs1,
  input  logic [REG_SEL-1:0]   id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_SEL-1:0]   ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_stall,
  output logic                 ex_mem_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic                 redirect_pending,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [0:0] c_st_run      = 1'b0;
  localparam logic [0:0] c_st_redirect = 1'b1;

  localparam logic [CNT_WIDTH-1:0] c_timeout    = CNT_WIDTH'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_timeout_m1 = CNT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;

  logic [0:0]           state_q,       state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q,    wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic w_mem_wait;
  logic w_load_use;

  assign w_mem_wait = mem_req & ~mem_ready;

  // Register 0 is hard-wired zero, so a load targeting it never hazards.
  assign w_load_use = ex_mem_read & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= c_st_run;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    // A frozen EX re-presents branch_taken once memory completes, so the FSM
    // only moves on non-wait cycles.
    if (!w_mem_wait) begin
      if (branch_taken) begin
        state_d = c_st_redirect;
      end else begin
        state_d = c_st_run;
      end
    end

    if (w_mem_wait) begin
      wait_cnt_d = (wait_cnt_q < c_timeout) ? wait_cnt_q + 1'b1 : wait_cnt_q;
      // Flag as the counter steps onto MEM_TIMEOUT, i.e. at the end of the
      // MEM_TIMEOUT-th consecutive wait cycle.
      if (wait_cnt_q >= c_timeout_m1) begin
        mem_timeout_d = 1'b1;
      end
    end

    if (pc_stall && (stall_count_q != c_cnt_max)) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    if (!w_mem_wait && branch_taken && (flush_count_q != c_cnt_max)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (combinational, same-cycle response)
  // --------------------------------------------------------------------------
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (w_mem_wait) begin
      // Freeze everything up to EX/MEM and drain a bubble into WB.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == c_st_redirect) begin
      // Second squash cycle: the synchronous IMEM returns the wrong-path
      // fetch now; ID holds a bubble, so no load-use check is needed.
      if_id_flush = 1'b1;
    end else if (w_load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign redirect_pending = (state_q == c_st_redirect);
  assign mem_timeout      = mem_timeout_q;
  assign stall_count      = stall_count_q;
  assign flush_count      = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. The driver applies one
//               directed vector per cycle and queues the expected strobes and
//               counter values. The monitor pops the queue and compares the
//               outputs on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_SEL     = 5;
  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_WIDTH   = 4;

  // Strobe vector: {pc_s, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f,
  //                 mem_wb_f, redirect_pending}
  localparam logic [7:0] c_none  = 8'h00;
  localparam logic [7:0] c_lu    = 8'hC4;
  localparam logic [7:0] c_br    = 8'h0C;
  localparam logic [7:0] c_br_rd = 8'h0D;
  localparam logic [7:0] c_rd    = 8'h09;
  localparam logic [7:0] c_mw    = 8'hF2;
  localparam logic [7:0] c_mw_rd = 8'hF3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [REG_SEL-1:0]   id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic                 id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic                 ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic                 mem_req = 1'b0, mem_ready = 1'b0;
  logic                 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic                 if_id_flush, id_ex_flush, mem_wb_flush;
  logic                 redirect_pending, mem_timeout;
  logic [CNT_WIDTH-1:0] stall_count, flush_count;

  hazard_ctrl #(
    .REG_SEL     (REG_SEL),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .branch_taken     (branch_taken),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_ex_stall      (id_ex_stall),
    .ex_mem_stall     (ex_mem_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .mem_wb_flush     (mem_wb_flush),
    .redirect_pending (redirect_pending),
    .mem_timeout      (mem_timeout),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] s;
    logic       to;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // One vector per cycle; reset cycles are applied but not checked.
  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mq,
                      input logic my, input logic [7:0] s, input logic to,
                      input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    ex_rd        = rd;
    ex_mem_read  = mr;
    branch_taken = br;
    mem_req      = mq;
    mem_ready    = my;
    if (!r) begin
      e.name = nm;
      e.s    = s;
      e.to   = to;
      e.sc   = sc;
      e.fc   = fc;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_flush, redirect_pending};
        n_cmp++;
        if (act !== e.s || mem_timeout !== e.to ||
            int'(stall_count) != e.sc || int'(flush_count) != e.fc) begin
          n_bad++;
          $display("FAIL %s: got strobes=%h to=%b sc=%0d fc=%0d, want strobes=%h to=%b sc=%0d fc=%0d",
                   e.name, act, mem_timeout, stall_count, flush_count,
                   e.s, e.to, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //    name        rst rs1 rs2 u1 u2 rd mr br mq my  strobes  to sc fc
    step("rst0",      1,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    step("rst1",      1,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    step("reset_idle",0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    // Load-use
    step("lu_rs2",    0,  0,  5, 0, 1, 5, 1, 0, 0, 0, c_lu,    0, 0, 0);
    step("lu_after",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 1, 0);
    step("lu_rd0",    0,  0,  0, 0, 1, 0, 1, 0, 0, 0, c_none,  0, 1, 0);
    step("lu_nouse",  0,  0,  5, 0, 0, 5, 1, 0, 0, 0, c_none,  0, 1, 0);
    step("lu_rs1",    0,  7,  0, 1, 0, 7, 1, 0, 0, 0, c_lu,    0, 1, 0);
    step("lu_noload", 0,  7,  0, 1, 0, 7, 0, 0, 0, 0, c_none,  0, 2, 0);
    // Taken branch, then REDIRECT with a load-use pattern present
    step("br_T",      0,  0,  0, 0, 0, 0, 0, 1, 0, 0, c_br,    0, 2, 0);
    step("br_T1",     0,  0,  5, 0, 1, 5, 1, 0, 0, 0, c_rd,    0, 2, 1);
    step("br_T2",     0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 2, 1);
    // Memory wait with branch_taken held; timeout sets after the 3rd wait
    step("mw_0",      0,  0,  0, 0, 0, 0, 0, 1, 1, 0, c_mw,    0, 2, 1);
    step("mw_1",      0,  0,  0, 0, 0, 0, 0, 1, 1, 0, c_mw,    0, 3, 1);
    step("mw_2",      0,  0,  0, 0, 0, 0, 0, 1, 1, 0, c_mw,    0, 4, 1);
    step("mw_3",      0,  0,  0, 0, 0, 0, 0, 1, 1, 0, c_mw,    1, 5, 1);
    step("mw_ready",  0,  0,  0, 0, 0, 0, 0, 1, 1, 1, c_br,    1, 6, 1);
    step("mw_redir",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_rd,    1, 6, 2);
    step("mw_run",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  1, 6, 2);
    // Memory wait while in REDIRECT
    step("rw_br",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, c_br,    1, 6, 2);
    step("rw_w0",     0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw_rd, 1, 6, 3);
    step("rw_w1",     0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw_rd, 1, 7, 3);
    step("rw_flush",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_rd,    1, 8, 3);
    step("rw_run",    0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  1, 8, 3);
    // Reset in the middle of REDIRECT
    step("rr_br",     0,  0,  0, 0, 0, 0, 0, 1, 0, 0, c_br,    1, 8, 3);
    step("rr_rst",    1,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    step("rr_after",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    // Dedicated timeout: 5 wait cycles, then release
    step("to_0",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw,    0, 0, 0);
    step("to_1",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw,    0, 1, 0);
    step("to_2",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw,    0, 2, 0);
    step("to_3",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw,    1, 3, 0);
    step("to_4",      0,  0,  0, 0, 0, 0, 0, 0, 1, 0, c_mw,    1, 4, 0);
    step("to_drop",   0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  1, 5, 0);
    step("to_sticky", 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  1, 5, 0);
    step("to_rst",    1,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    step("to_clear",  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, c_none,  0, 0, 0);
    // Stall counter saturation (4-bit counter, max 15)
    for (int i = 0; i < 18; i++) begin
      step($sformatf("sat_stall%0d", i), 0, 0, 5, 0, 1, 5, 1, 0, 0, 0,
           c_lu, 0, (i < 15) ? i : 15, 0);
    end
    step("sat_stall_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_none, 0, 15, 0);
    // Flush counter saturation with back-to-back branches
    for (int i = 0; i < 18; i++) begin
      step($sformatf("sat_flush%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
           (i == 0) ? c_br : c_br_rd, 0, 15, (i < 15) ? i : 15);
    end
    step("sat_flush_rd",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_rd,   0, 15, 15);
    step("sat_flush_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_none, 0, 15, 15);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
